// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: counted multiply-accumulate latency plus an iterative restoring divider.
// Optional build macro MULDIV_CANCEL_EN adds the cancel (exception flush) input.
module muldiv_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [1:0]       rd_sel,
`ifdef MULDIV_CANCEL_EN
    input  logic             cancel,
`endif
    output logic             busy,
    output logic [WIDTH-1:0] result
);
    localparam int CNT_MAX = (MUL_LAT > WIDTH + 1) ? MUL_LAT : WIDTH + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE_FIX} state_t;

    state_t             state, next_state;
    logic               flush;
    logic [WIDTH-1:0]   hi, lo, a_reg, b_reg, quo, rem;
    logic [CNT_W-1:0]   count;
    logic               op_signed, mul_add, mul_sub, neg_q, neg_r, div_zero;
    logic               is_mul, is_div, src_signed;
    logic [WIDTH-1:0]   a_mag, b_mag, q_fix, r_fix;
    logic [2*WIDTH-1:0] ext_a, ext_b, product, mul_result;
    logic [WIDTH:0]     shifted, trial;

`ifdef MULDIV_CANCEL_EN
    assign flush = cancel;
`else
    assign flush = 1'b0;
`endif

    always_comb begin
        is_mul     = 1'b0;
        is_div     = 1'b0;
        src_signed = 1'b0;
        case (op)
            OP_MULT, OP_MADD, OP_MSUB: begin
                is_mul     = 1'b1;
                src_signed = 1'b1;
            end
            OP_MULTU, OP_MADDU, OP_MSUBU: is_mul = 1'b1;
            OP_DIV: begin
                is_div     = 1'b1;
                src_signed = 1'b1;
            end
            OP_DIVU: is_div = 1'b1;
            default: ;
        endcase
    end

    assign a_mag = (src_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    assign b_mag = (src_signed && src_b[WIDTH-1]) ? -src_b : src_b;

    // Sign-extending to 2*WIDTH lets one unsigned multiplier produce both signed and unsigned products.
    assign ext_a   = op_signed ? {{WIDTH{a_reg[WIDTH-1]}}, a_reg} : {{WIDTH{1'b0}}, a_reg};
    assign ext_b   = op_signed ? {{WIDTH{b_reg[WIDTH-1]}}, b_reg} : {{WIDTH{1'b0}}, b_reg};
    assign product = ext_a * ext_b;

    always_comb begin
        mul_result = product;
        if (mul_add)
            mul_result = {hi, lo} + product;
        else if (mul_sub)
            mul_result = {hi, lo} - product;
    end

    // Restoring step: quo shifts the dividend out at the top while quotient bits enter at the bottom.
    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, b_reg};
    assign q_fix   = neg_q ? -quo : quo;
    assign r_fix   = neg_r ? -rem : rem;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!flush && is_mul)
                    next_state = MUL;
                else if (!flush && is_div)
                    next_state = DIV;
            end
            MUL:      if (flush || count == '0) next_state = IDLE;
            DIV: begin
                if (flush)
                    next_state = IDLE;
                else if (count == '0)
                    next_state = DONE_FIX;
            end
            DONE_FIX: next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi        <= '0;
            lo        <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            quo       <= '0;
            rem       <= '0;
            count     <= '0;
            op_signed <= 1'b0;
            mul_add   <= 1'b0;
            mul_sub   <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div_zero  <= 1'b0;
        end else if (!flush) begin
            case (state)
                IDLE: begin
                    if (op == OP_MTHI)
                        hi <= src_a;
                    else if (op == OP_MTLO)
                        lo <= src_a;
                    else if (is_mul) begin
                        a_reg     <= src_a;
                        b_reg     <= src_b;
                        op_signed <= src_signed;
                        mul_add   <= (op == OP_MADD) || (op == OP_MADDU);
                        mul_sub   <= (op == OP_MSUB) || (op == OP_MSUBU);
                        count     <= CNT_W'(MUL_LAT - 1);
                    end else if (is_div) begin
                        a_reg    <= src_a;
                        b_reg    <= b_mag;
                        quo      <= a_mag;
                        rem      <= '0;
                        neg_q    <= src_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        neg_r    <= src_signed && src_a[WIDTH-1];
                        div_zero <= (src_b == '0);
                        count    <= CNT_W'(WIDTH - 1);
                    end
                end
                MUL: begin
                    if (count == '0)
                        {hi, lo} <= mul_result;
                    else
                        count <= count - 1'b1;
                end
                DIV: begin
                    if (trial[WIDTH]) begin
                        rem <= shifted[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end else begin
                        rem <= trial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end
                    if (count != '0)
                        count <= count - 1'b1;
                end
                DONE_FIX: begin
                    if (div_zero) begin
                        hi <= a_reg;
                        lo <= '1;
                    end else begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        result = '0;
        case (rd_sel)
            2'd1:    result = hi;
            2'd2:    result = lo;
            default: result = '0;
        endcase
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32, MUL_LAT=5); define MULDIV_CANCEL_EN to exercise cancel.
module tb_muldiv_unit;
    localparam int W   = 32;
    localparam int LAT = 5;

    localparam logic [3:0] NOP   = 4'd0;
    localparam logic [3:0] MULT  = 4'd1;
    localparam logic [3:0] MULTU = 4'd2;
    localparam logic [3:0] DIV   = 4'd3;
    localparam logic [3:0] DIVU  = 4'd4;
    localparam logic [3:0] MADD  = 4'd5;
    localparam logic [3:0] MADDU = 4'd6;
    localparam logic [3:0] MSUB  = 4'd7;
    localparam logic [3:0] MSUBU = 4'd8;
    localparam logic [3:0] MTHI  = 4'd9;
    localparam logic [3:0] MTLO  = 4'd10;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [3:0]   op = NOP;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic [1:0]   rd_sel = 2'd0;
    logic         busy;
    logic [W-1:0] result;
`ifdef MULDIV_CANCEL_EN
    logic         cancel = 1'b0;
`endif

    int           checks = 0;
    int           failures = 0;
    logic [63:0]  expect_q[$];
    logic [31:0]  mhi = '0;
    logic [31:0]  mlo = '0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W), .MUL_LAT(LAT)) dut (
        .clk(clk),
        .reset(reset),
        .op(op),
        .src_a(src_a),
        .src_b(src_b),
        .rd_sel(rd_sel),
`ifdef MULDIV_CANCEL_EN
        .cancel(cancel),
`endif
        .busy(busy),
        .result(result)
    );

    // Reference arithmetic written with native 64-bit operators, independent of the shift-subtract datapath.
    function automatic logic [63:0] model_op(input logic [3:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
        longint      sa, sb;
        logic [63:0] sp, up, res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        sp  = sa * sb;
        up  = {32'd0, a} * {32'd0, b};
        res = acc;
        case (o)
            MULT:  res = sp;
            MULTU: res = up;
            MADD:  res = acc + sp;
            MADDU: res = acc + up;
            MSUB:  res = acc - sp;
            MSUBU: res = acc - up;
            DIV: begin
                if (b == 32'd0)
                    res = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    res = {32'd0, 32'h8000_0000};
                else
                    res = {32'(sa % sb), 32'(sa / sb)};
            end
            DIVU: begin
                if (b == 32'd0)
                    res = {a, 32'hFFFF_FFFF};
                else
                    res = {a % b, a / b};
            end
            default: res = acc;
        endcase
        return res;
    endfunction

    task automatic issue_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clk);
        #1;
        op = NOP;
    endtask

    // Consumer side of the scoreboard: counts busy cycles, checks HI is held, then pops and compares.
    task automatic wait_done(input string name, input int exp_cycles, input int already);
        int          cycles;
        bit          done;
        logic [63:0] exp;
        logic [31:0] got_hi, got_lo;
        cycles = already;
        done   = 0;
        rd_sel = 2'd1;
        while (!done) begin
            @(negedge clk);
            if (busy !== 1'b1) begin
                done = 1;
            end else begin
                cycles++;
                checks++;
                if (result !== mhi) begin
                    failures++;
                    $display("[TB] FAIL %s_hold: HI read %h during busy, required old %h", name, result, mhi);
                end
                if (cycles > 200) begin
                    failures++;
                    $display("[TB] FAIL %s_timeout: busy still %b after %0d cycles, required 0", name, busy, cycles);
                    done = 1;
                end
            end
        end
        checks++;
        if (cycles != exp_cycles) begin
            failures++;
            $display("[TB] FAIL %s_cycles: busy for %0d cycles, required %0d", name, cycles, exp_cycles);
        end
        rd_sel = 2'd1;
        #1 got_hi = result;
        rd_sel = 2'd2;
        #1 got_lo = result;
        checks++;
        if (expect_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL %s_queue: scoreboard empty, required one entry", name);
        end else begin
            exp = expect_q.pop_front();
            if ({got_hi, got_lo} !== exp) begin
                failures++;
                $display("[TB] FAIL %s: HI/LO %h_%h, required %h_%h", name, got_hi, got_lo, exp[63:32], exp[31:0]);
            end
            mhi = exp[63:32];
            mlo = exp[31:0];
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busy: busy %b, required 0", busy);
        end
        for (int s = 0; s < 4; s++) begin
            rd_sel = 2'(s);
            #1;
            checks++;
            if (result !== 32'd0) begin
                failures++;
                $display("[TB] FAIL reset_result: rd_sel %0d reads %h, required 0", s, result);
            end
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult();
        expect_q.push_back(64'hFFFF_FFFF_FFFF_FFFA);
        issue_op(MULT, 32'hFFFF_FFFE, 32'd3);
        wait_done("mult", LAT, 0);
    endtask

    task automatic test_div();
        expect_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
        issue_op(DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_signed", W + 1, 0);
        expect_q.push_back({32'd1, 32'h7FFF_FFFC});
        issue_op(DIVU, 32'hFFFF_FFF9, 32'd2);
        wait_done("divu", W + 1, 0);
    endtask

    task automatic test_accumulate();
        issue_op(MTLO, 32'd5, 32'd0);
        mlo = 32'd5;
        issue_op(MTHI, 32'd0, 32'd0);
        mhi = 32'd0;
        @(negedge clk);
        rd_sel = 2'd2;
        #1;
        checks++;
        if (result !== 32'd5) begin
            failures++;
            $display("[TB] FAIL mtlo: LO %h, required 00000005", result);
        end
        rd_sel = 2'd1;
        #1;
        checks++;
        if (result !== 32'd0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mthi: HI %h busy %b, required 00000000 busy 0", result, busy);
        end
        expect_q.push_back({32'd2, 32'd3});
        issue_op(MADDU, 32'hFFFF_FFFF, 32'd2);
        wait_done("maddu", LAT, 0);
        expect_q.push_back({32'd1, 32'hFFFF_FFFF});
        issue_op(MSUB, 32'd1, 32'd4);
        wait_done("msub", LAT, 0);
    endtask

    task automatic test_div_boundaries();
        expect_q.push_back({32'h0000_1234, 32'hFFFF_FFFF});
        issue_op(DIVU, 32'h0000_1234, 32'd0);
        wait_done("divu_by_zero", W + 1, 0);
        expect_q.push_back({32'd0, 32'h8000_0000});
        issue_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_min_neg1", W + 1, 0);
    endtask

    task automatic test_busy_ignore();
        expect_q.push_back(64'd12);
        issue_op(MULTU, 32'd3, 32'd4);
        op     = MTHI;
        src_a  = 32'hDEAD_BEEF;
        rd_sel = 2'd1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || result !== mhi) begin
                failures++;
                $display("[TB] FAIL busy_ignore_hi: busy %b HI %h, required busy 1 HI %h", busy, result, mhi);
            end
        end
        op = NOP;
        wait_done("busy_ignore", LAT, 2);
    endtask

    task automatic test_cancel();
`ifdef MULDIV_CANCEL_EN
        issue_op(MULT, 32'd7, 32'd9);
        repeat (2) @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        rd_sel = 2'd1;
        #1;
        checks++;
        if (busy !== 1'b0 || result !== mhi) begin
            failures++;
            $display("[TB] FAIL cancel_mult: busy %b HI %h, required busy 0 HI %h", busy, result, mhi);
        end
        rd_sel = 2'd2;
        #1;
        checks++;
        if (result !== mlo) begin
            failures++;
            $display("[TB] FAIL cancel_mult_lo: LO %h, required %h", result, mlo);
        end
        @(negedge clk);
        cancel = 1'b1;
        issue_op(MTHI, 32'hCAFE_0001, 32'd0);
        cancel = 1'b0;
        rd_sel = 2'd1;
        #1;
        checks++;
        if (result !== mhi || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL cancel_mthi: HI %h busy %b, required HI %h busy 0", result, busy, mhi);
        end
`else
        expect_q.push_back(64'd63);
        issue_op(MULT, 32'd7, 32'd9);
        wait_done("no_cancel_mult", LAT, 0);
`endif
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [3:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 10; i++) begin
            o = 4'($urandom_range(1, 10));
            a = $urandom();
            b = (i == 3) ? 32'd0 : $urandom();
            if (i % 4 == 1)
                b = b >> $urandom_range(0, 31);
            if (o == MTHI || o == MTLO) begin
                issue_op(o, a, b);
                if (o == MTHI) mhi = a;
                else           mlo = a;
                @(negedge clk);
                rd_sel = (o == MTHI) ? 2'd1 : 2'd2;
                #1;
                checks++;
                if (result !== a) begin
                    failures++;
                    $display("[TB] FAIL b2b_move: op %0d reads %h, required %h", o, result, a);
                end
            end else begin
                expect_q.push_back(model_op(o, a, b, {mhi, mlo}));
                issue_op(o, a, b);
                wait_done("b2b", (o == DIV || o == DIVU) ? W + 1 : LAT, 0);
            end
        end
    endtask

    task automatic test_reset_mid_div();
        issue_op(MTLO, 32'h0000_0055, 32'd0);
        issue_op(MTHI, 32'h0000_00AA, 32'd0);
        issue_op(DIV, 32'h0000_1000, 32'd3);
        repeat (9) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_div_busy: busy %b, required 0", busy);
        end
        rd_sel = 2'd1;
        #1;
        checks++;
        if (result !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_mid_div_hi: HI %h, required 0", result);
        end
        rd_sel = 2'd2;
        #1;
        checks++;
        if (result !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_mid_div_lo: LO %h, required 0", result);
        end
        mhi = '0;
        mlo = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_accumulate();
        test_div_boundaries();
        test_busy_ignore();
        test_cancel();
        test_back_to_back();
        test_reset_mid_div();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
